// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the pipeline modules around it:
// loader state encoding and default instruction-memory addressing parameters.
package prog_loader_pkg;

   localparam int PC_SIZE_DEFAULT = 10;
   localparam int PC_STEP_DEFAULT = 4;
   localparam int WORD_BYTES      = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      WRITE,
      RELEASE,
      RUN
   } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words: the first byte of a word
// ends up in bits [7:0], the fourth in bits [31:24].
module word_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0] byte_count;

   // Full strobes on the same edge the fourth byte is shifted in, so the
   // loader can stop accepting bytes without a bubble.
   assign full = accept && (byte_count == 2'd3);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         word       <= 32'd0;
         byte_count <= 2'd0;
      end else if (accept) begin
         word       <= {byte_in, word[31:8]};
         byte_count <= byte_count + 2'd1;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory while holding the core in reset,
// then releases the core. All outputs come straight from flops.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int PC_SIZE = PC_SIZE_DEFAULT,
   parameter int PC_STEP = PC_STEP_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [PC_SIZE-1:0] word_count,
   input  logic               byte_valid,
   input  logic [7:0]         byte_in,
   output logic               byte_ready,
   output logic               rw,
   output logic               reset_IF_memory,
   output logic [PC_SIZE-1:0] PC_write,
   output logic [31:0]        instruction_in,
   output logic               core_reset,
   output logic               busy,
   output logic               done
);

   loader_state_t      state;
   logic [PC_SIZE-1:0] word_total;
   logic [PC_SIZE-1:0] words_written;
   logic               release_count;
   logic               accept;
   logic               word_full;
   logic               clear_word;

   assign accept     = byte_valid && byte_ready;
   assign clear_word = (state == CLEAR);

   word_assembler u_word_assembler (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear_word),
      .accept  (accept),
      .byte_in (byte_in),
      .word    (instruction_in),
      .full    (word_full)
   );

   // Each transition also loads the output flops with the values of the state
   // being entered, so outputs line up with the state without extra logic.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         core_reset      <= 1'b1;
         rw              <= 1'b0;
         reset_IF_memory <= 1'b0;
         byte_ready      <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         PC_write        <= '0;
         word_total      <= '0;
         words_written   <= '0;
         release_count   <= 1'b0;
      end else begin
         rw              <= 1'b0;
         reset_IF_memory <= 1'b0;
         case (state)
            IDLE, RUN: begin
               if (start) begin
                  state           <= CLEAR;
                  word_total      <= word_count;
                  words_written   <= '0;
                  PC_write        <= '0;
                  reset_IF_memory <= 1'b1;
                  core_reset      <= 1'b1;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  byte_ready      <= 1'b0;
               end
            end
            CLEAR: begin
               if (word_total != '0) begin
                  state      <= LOAD;
                  byte_ready <= 1'b1;
               end else begin
                  state         <= RELEASE;
                  release_count <= 1'b0;
               end
            end
            LOAD: begin
               if (word_full) begin
                  state      <= WRITE;
                  byte_ready <= 1'b0;
                  rw         <= 1'b1;
               end
            end
            WRITE: begin
               words_written <= words_written + PC_SIZE'(1);
               if ((words_written + PC_SIZE'(1)) == word_total) begin
                  state         <= RELEASE;
                  release_count <= 1'b0;
               end else begin
                  PC_write   <= PC_write + PC_SIZE'(PC_STEP);
                  state      <= LOAD;
                  byte_ready <= 1'b1;
               end
            end
            // Core reset stays asserted for two full cycles after the last write.
            RELEASE: begin
               if (release_count) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  release_count <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: default instance plus a
// PC_SIZE=4 instance for address wrap.
module tb_prog_loader;

   logic       clock;
   logic       reset;
   logic       start;
   logic       start4;
   logic [9:0] wordCount;
   logic [3:0] wordCount4;
   logic       byteValid;
   logic [7:0] byteIn;

   logic        byteReady, rw, rif, coreReset, busy, done;
   logic [9:0]  pcWrite;
   logic [31:0] instrIn;

   logic        byteReady4, rw4, rif4, coreReset4, busy4, done4;
   logic [3:0]  pcWrite4;
   logic [31:0] instrIn4;

   int checks   = 0;
   int failures = 0;
   int rifCount = 0;
   int overlapCount = 0;

   logic [31:0] wrPc[$];
   logic [31:0] wrData[$];
   logic [31:0] wrPc4[$];
   logic [31:0] wrData4[$];

   logic [7:0]  load2[8]       = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
   logic [7:0]  toggleBytes[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic [31:0] expPc4[5]      = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0};

   prog_loader dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .word_count      (wordCount),
      .byte_valid      (byteValid),
      .byte_in         (byteIn),
      .byte_ready      (byteReady),
      .rw              (rw),
      .reset_IF_memory (rif),
      .PC_write        (pcWrite),
      .instruction_in  (instrIn),
      .core_reset      (coreReset),
      .busy            (busy),
      .done            (done)
   );

   prog_loader #(.PC_SIZE(4), .PC_STEP(4)) dut4 (
      .clock           (clock),
      .reset           (reset),
      .start           (start4),
      .word_count      (wordCount4),
      .byte_valid      (byteValid),
      .byte_in         (byteIn),
      .byte_ready      (byteReady4),
      .rw              (rw4),
      .reset_IF_memory (rif4),
      .PC_write        (pcWrite4),
      .instruction_in  (instrIn4),
      .core_reset      (coreReset4),
      .busy            (busy4),
      .done            (done4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Records every memory write and clear pulse seen mid-cycle.
   always @(negedge clock) begin
      if (rw === 1'b1) begin
         wrPc.push_back(32'(pcWrite));
         wrData.push_back(instrIn);
      end
      if (rw4 === 1'b1) begin
         wrPc4.push_back(32'(pcWrite4));
         wrData4.push_back(instrIn4);
      end
      if (rif === 1'b1) rifCount++;
      if ((rw === 1'b1 && rif === 1'b1) || (rw4 === 1'b1 && rif4 === 1'b1)) overlapCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one byte and holds it until the selected loader accepts it.
   task automatic applyStimulus(input bit useSmall, input logic [7:0] b);
      logic rdy;
      byteIn    = b;
      byteValid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rdy = useSmall ? byteReady4 : byteReady;
         @(posedge clock); #1;
         if (rdy === 1'b1) return;
      end
      rdy = useSmall ? byteReady4 : byteReady;
      checkOutput("byte_accept_timeout", 32'(rdy), 32'd1);
   endtask

   task automatic waitDone(input bit useSmall, input int maxCycles);
      for (int i = 0; i < maxCycles; i++) begin
         if ((useSmall ? done4 : done) === 1'b1) break;
         @(posedge clock); #1;
      end
      checkOutput(useSmall ? "done4_reached" : "done_reached", 32'(useSmall ? done4 : done), 32'd1);
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   initial begin
      int accepted;
      int cyc;
      logic rdy;

      reset = 1'b1; start = 1'b0; start4 = 1'b0;
      wordCount = '0; wordCount4 = '0; byteValid = 1'b0; byteIn = '0;
      step(); step();

      $display("[TB] reset state");
      checkOutput("rst_core_reset",  32'(coreReset), 32'd1);
      checkOutput("rst_rw",          32'(rw),        32'd0);
      checkOutput("rst_rif",         32'(rif),       32'd0);
      checkOutput("rst_byte_ready",  32'(byteReady), 32'd0);
      checkOutput("rst_busy",        32'(busy),      32'd0);
      checkOutput("rst_done",        32'(done),      32'd0);
      checkOutput("rst_pc",          32'(pcWrite),   32'd0);
      checkOutput("rst_instr",       instrIn,        32'd0);
      checkOutput("rst4_core_reset", 32'(coreReset4), 32'd1);

      reset = 1'b0;
      step();
      checkOutput("idle_core_reset", 32'(coreReset), 32'd1);
      checkOutput("idle_byte_ready", 32'(byteReady), 32'd0);

      $display("[TB] two-word load");
      wrPc.delete(); wrData.delete(); rifCount = 0;
      wordCount = 10'd2; start = 1'b1;
      step();
      wordCount = 10'd7;
      checkOutput("clr_rif",        32'(rif),       32'd1);
      checkOutput("clr_busy",       32'(busy),      32'd1);
      checkOutput("clr_byte_ready", 32'(byteReady), 32'd0);
      step();
      start = 1'b0;
      checkOutput("load_rif",        32'(rif),       32'd0);
      checkOutput("load_byte_ready", 32'(byteReady), 32'd1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, load2[i]);
      byteValid = 1'b0;
      checkOutput("w2_rw",    32'(rw),      32'd1);
      checkOutput("w2_pc",    32'(pcWrite), 32'd4);
      checkOutput("w2_instr", instrIn,      32'h00200093);
      step();
      checkOutput("rel1_rw",   32'(rw),   32'd0);
      checkOutput("rel1_busy", 32'(busy), 32'd1);
      checkOutput("rel1_done", 32'(done), 32'd0);
      step();
      checkOutput("rel2_done",       32'(done),      32'd0);
      checkOutput("rel2_core_reset", 32'(coreReset), 32'd1);
      step();
      checkOutput("run_done",       32'(done),      32'd1);
      checkOutput("run_core_reset", 32'(coreReset), 32'd0);
      checkOutput("run_busy",       32'(busy),      32'd0);
      checkOutput("two_write_count", 32'(wrPc.size()), 32'd2);
      checkOutput("two_w0_pc",   wrPc[0],   32'd0);
      checkOutput("two_w0_data", wrData[0], 32'h00100013);
      checkOutput("two_w1_pc",   wrPc[1],   32'd4);
      checkOutput("two_w1_data", wrData[1], 32'h00200093);
      checkOutput("two_rif_count", 32'(rifCount), 32'd1);

      $display("[TB] restart from RUN with toggling byte_valid");
      wrPc.delete(); wrData.delete(); rifCount = 0;
      wordCount = 10'd1; start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("rst_run_core_reset", 32'(coreReset), 32'd1);
      checkOutput("rst_run_rif",        32'(rif),       32'd1);
      checkOutput("rst_run_pc",         32'(pcWrite),   32'd0);
      checkOutput("rst_run_done",       32'(done),      32'd0);
      accepted = 0;
      cyc = 0;
      while (accepted < 4 && cyc < 40) begin
         byteValid = (cyc % 2 == 0);
         byteIn    = byteValid ? toggleBytes[accepted] : 8'h55;
         rdy       = byteReady;
         step();
         if (byteValid && rdy === 1'b1) accepted++;
         cyc++;
      end
      byteValid = 1'b0;
      checkOutput("toggle_accepted", 32'(accepted), 32'd4);
      waitDone(1'b0, 10);
      checkOutput("toggle_write_count", 32'(wrPc.size()), 32'd1);
      checkOutput("toggle_pc",   wrPc[0],   32'd0);
      checkOutput("toggle_data", wrData[0], 32'hDEADBEEF);
      checkOutput("toggle_rif_count", 32'(rifCount), 32'd1);

      $display("[TB] zero-word load");
      wrPc.delete(); wrData.delete(); rifCount = 0;
      wordCount = 10'd0; start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("zero_c1_rif", 32'(rif), 32'd1);
      step();
      checkOutput("zero_c2_rif",        32'(rif),       32'd0);
      checkOutput("zero_c2_byte_ready", 32'(byteReady), 32'd0);
      checkOutput("zero_c2_done",       32'(done),      32'd0);
      step();
      checkOutput("zero_c3_done", 32'(done), 32'd0);
      step();
      checkOutput("zero_c4_done", 32'(done), 32'd1);
      checkOutput("zero_write_count", 32'(wrPc.size()), 32'd0);
      checkOutput("zero_rif_count",   32'(rifCount),    32'd1);

      $display("[TB] reset mid-load");
      wrPc.delete(); wrData.delete();
      wordCount = 10'd2; start = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, load2[i]);
      byteValid = 1'b0;
      checkOutput("abort_pre_writes", 32'(wrPc.size()), 32'd1);
      reset = 1'b1; start = 1'b1;
      step();
      checkOutput("abort_busy",       32'(busy),      32'd0);
      checkOutput("abort_core_reset", 32'(coreReset), 32'd1);
      checkOutput("abort_pc",         32'(pcWrite),   32'd0);
      checkOutput("abort_instr",      instrIn,        32'd0);
      checkOutput("abort_byte_ready", 32'(byteReady), 32'd0);
      checkOutput("abort_rif",        32'(rif),       32'd0);
      reset = 1'b0; start = 1'b0;
      wrPc.delete(); wrData.delete();
      byteValid = 1'b1; byteIn = 8'hAA;
      repeat (10) step();
      byteValid = 1'b0;
      checkOutput("abort_no_writes",   32'(wrPc.size()), 32'd0);
      checkOutput("abort_idle_busy",   32'(busy),        32'd0);
      checkOutput("abort_idle_core",   32'(coreReset),   32'd1);
      checkOutput("abort_idle_ready",  32'(byteReady),   32'd0);

      $display("[TB] PC wrap with PC_SIZE=4");
      wrPc4.delete(); wrData4.delete();
      wordCount4 = 4'd5; start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i));
      byteValid = 1'b0;
      waitDone(1'b1, 10);
      checkOutput("wrap_write_count", 32'(wrPc4.size()), 32'd5);
      for (int n = 0; n < 5; n++) begin
         checkOutput($sformatf("wrap_pc%0d", n), wrPc4[n], expPc4[n]);
         checkOutput($sformatf("wrap_data%0d", n), wrData4[n],
                     {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)});
      end

      checkOutput("rw_rif_overlap", 32'(overlapCount), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
